// File: rtl/fp_acc_dump_pkg.sv
// Shared definitions for the fixed-point integrate-and-dump block:
// default number formats, block length, a ceil-log2 helper and FSM states.
package fp_acc_dump_pkg;

    localparam int DEF_NB_IN   = 12;
    localparam int DEF_NBF_IN  = 11;
    localparam int DEF_NB_OUT  = 10;
    localparam int DEF_NBF_OUT = 9;
    localparam int DEF_N_ACC   = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // Smallest r such that 2**r >= v (v >= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_sat_round.sv
// Combinational requantiser: drops NBF_I-NBF_O fractional LSBs (round half up
// when FP_ACC_ROUND_EN is defined, floor otherwise) and saturates to NB_O bits.
// Macro: FP_ACC_ROUND_EN
module fp_sat_round #(
    parameter int NB_I  = 15,
    parameter int NBF_I = 11,
    parameter int NB_O  = 10,
    parameter int NBF_O = 9
) (
    input  logic [NB_I-1:0] i_data,
    output logic [NB_O-1:0] o_data,
    output logic            o_sat
);

    localparam int D    = NBF_I - NBF_O;
    // One extra bit so the rounding increment can never wrap.
    localparam int NB_W = NB_I + 1;
    localparam int NB_H = NB_W - NB_O + 1;

`ifdef FP_ACC_ROUND_EN
    // Half an output LSB; evaluates to zero when no bits are dropped.
    localparam logic [NB_W-1:0] RND = NB_W'((1 << D) >> 1);
`else
    localparam logic [NB_W-1:0] RND = '0;
`endif

    localparam logic [NB_O-1:0] POS_MAX = {1'b0, {(NB_O-1){1'b1}}};
    localparam logic [NB_O-1:0] NEG_MIN = {1'b1, {(NB_O-1){1'b0}}};

    logic [NB_W-1:0] w_ext;
    logic [NB_W-1:0] w_rnd;
    logic [NB_W-1:0] w_shr;
    logic [NB_H-1:0] w_high;
    logic            w_fits;

    // Round, drop LSBs, then saturate if the result exceeds NB_O bits.
    always_comb begin
        w_ext  = {i_data[NB_I-1], i_data};
        w_rnd  = w_ext + RND;
        w_shr  = $signed(w_rnd) >>> D;
        w_high = w_shr[NB_W-1:NB_O-1];
        w_fits = (w_high == '0) || (w_high == '1);
        o_sat  = ~w_fits;
        if (w_fits) begin
            o_data = w_shr[NB_O-1:0];
        end else if (w_shr[NB_W-1]) begin
            o_data = NEG_MIN;
        end else begin
            o_data = POS_MAX;
        end
    end

endmodule

// File: rtl/fp_acc_dump.sv
// Integrate-and-dump accumulator: sums N_ACC signed products with guard bits
// and emits one saturated/requantised result per block as a 1-cycle pulse.
// Macro: FP_ACC_ROUND_EN (round half up instead of floor in fp_sat_round).
module fp_acc_dump
    import fp_acc_dump_pkg::*;
#(
    parameter int NB_IN   = DEF_NB_IN,
    parameter int NBF_IN  = DEF_NBF_IN,
    parameter int N_ACC   = DEF_N_ACC,
    parameter int NB_OUT  = DEF_NB_OUT,
    parameter int NBF_OUT = DEF_NBF_OUT
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [NB_IN-1:0]  i_data,
    input  logic              i_clear,
    output logic              o_valid,
    output logic [NB_OUT-1:0] o_data,
    output logic              o_sat,
    output logic              o_busy
);

    localparam int NB_G   = clog2(N_ACC);
    localparam int NB_ACC = NB_IN + NB_G;
    localparam logic [NB_G-1:0] CNT_LAST = NB_G'(N_ACC - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [NB_ACC-1:0]   r_acc;
    logic [NB_ACC-1:0]   w_acc_next;
    logic [NB_G-1:0]     r_cnt;
    logic [NB_G-1:0]     w_cnt_next;
    logic                r_valid;
    logic [NB_OUT-1:0]   r_data;
    logic                r_sat;

    logic [NB_ACC-1:0]   w_x;
    logic [NB_ACC-1:0]   w_sum;
    logic                w_last;
    logic                w_fire;
    logic [NB_OUT-1:0]   w_q_data;
    logic                w_q_sat;

    assign w_x    = {{NB_G{i_data[NB_IN-1]}}, i_data};
    assign w_sum  = r_acc + w_x;
    assign w_last = (r_cnt == CNT_LAST);

    fp_sat_round #(
        .NB_I  (NB_ACC),
        .NBF_I (NBF_IN),
        .NB_O  (NB_OUT),
        .NBF_O (NBF_OUT)
    ) u_sat_round (
        .i_data (w_sum),
        .o_data (w_q_data),
        .o_sat  (w_q_sat)
    );

    // Next-state logic: clear wins over a sample; final sample dumps and restarts.
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_fire       = 1'b0;
        if (i_clear) begin
            w_state_next = ST_IDLE;
            w_acc_next   = '0;
            w_cnt_next   = '0;
        end else if (i_valid) begin
            if (w_last) begin
                w_fire       = 1'b1;
                w_state_next = ST_IDLE;
                w_acc_next   = '0;
                w_cnt_next   = '0;
            end else begin
                w_state_next = ST_ACCUM;
                w_acc_next   = w_sum;
                w_cnt_next   = r_cnt + 1'b1;
            end
        end
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_valid <= w_fire;
            if (w_fire) begin
                r_data <= w_q_data;
                r_sat  <= w_q_sat;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_sat   = r_sat;
    assign o_busy  = (r_state == ST_ACCUM);

endmodule

// File: tb/tb_fp_acc_dump.sv
// Directed self-checking bench for fp_acc_dump with default parameters.
module tb_fp_acc_dump;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic [11:0] i_data = '0;
    logic        i_clear = 1'b0;
    logic        o_valid;
    logic [9:0]  o_data;
    logic        o_sat;
    logic        o_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_acc_dump dut (
        .clk     (clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_clear (i_clear),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_sat   (o_sat),
        .o_busy  (o_busy)
    );

    // Apply inputs for one clock edge, then settle 1 time unit after it.
    task automatic step(input logic v, input logic [11:0] d, input logic c, input logic r);
        i_valid = v;
        i_data  = d;
        i_clear = c;
        i_reset = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'b0, 12'h000, 1'b0, 1'b1);
        step(1'b0, 12'h000, 1'b0, 1'b1);
        step(1'b0, 12'h000, 1'b0, 1'b0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        checks++; if (o_data !== 10'h000) begin errors++; $display("FAIL reset_data got %h exp 000", o_data); end
        checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b exp 0", o_sat); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    endtask

    // One block of 8 identical samples, checked cycle by cycle.
    task automatic run_block(input logic [11:0] d, input logic [9:0] exp_d, input logic exp_s, input string nm);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, d, 1'b0, 1'b0);
            checks++;
            if (o_valid !== (i == 7)) begin errors++; $display("FAIL %s_valid[%0d] got %b exp %b", nm, i, o_valid, (i == 7)); end
        end
        i_valid = 1'b0;
        checks++; if (o_data !== exp_d) begin errors++; $display("FAIL %s_data got %h exp %h", nm, o_data, exp_d); end
        checks++; if (o_sat !== exp_s) begin errors++; $display("FAIL %s_sat got %b exp %b", nm, o_sat, exp_s); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %b exp 0", nm, o_busy); end
    endtask

    task automatic test_basic;
        step(1'b1, 12'h080, 1'b0, 1'b0);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_first got %b exp 1", o_busy); end
        for (int i = 1; i < 7; i++) step(1'b1, 12'h080, 1'b0, 1'b0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early got %b exp 0", o_valid); end
        step(1'b1, 12'h080, 1'b0, 1'b0);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", o_valid); end
        checks++; if (o_data !== 10'h100) begin errors++; $display("FAIL basic_data got %h exp 100", o_data); end
        checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL basic_sat got %b exp 0", o_sat); end
        step(1'b0, 12'h000, 1'b0, 1'b0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b exp 0", o_valid); end
        checks++; if (o_data !== 10'h100) begin errors++; $display("FAIL basic_hold got %h exp 100", o_data); end
    endtask

    task automatic test_saturation;
        run_block(12'h200, 10'h1FF, 1'b1, "sat_pos");
        run_block(12'hC00, 10'h200, 1'b1, "sat_neg");
        run_block(12'h080, 10'h100, 1'b0, "sat_clear_flag");
    endtask

    task automatic test_rounding;
        logic [9:0] exp_pos;
`ifdef FP_ACC_ROUND_EN
        exp_pos = 10'h001;
`else
        exp_pos = 10'h000;
`endif
        step(1'b1, 12'h003, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 12'h000, 1'b0, 1'b0);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rnd_pos_valid got %b exp 1", o_valid); end
        checks++; if (o_data !== exp_pos) begin errors++; $display("FAIL rnd_pos_data got %h exp %h", o_data, exp_pos); end
        step(1'b1, 12'hFFD, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 12'h000, 1'b0, 1'b0);
        checks++; if (o_data !== 10'h3FF) begin errors++; $display("FAIL rnd_neg_data got %h exp 3ff", o_data); end
        checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL rnd_neg_sat got %b exp 0", o_sat); end
        step(1'b0, 12'h000, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        int pulses;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 12'h080, 1'b0, 1'b0);
            if (o_valid === 1'b1) pulses++;
            checks++;
            if (o_valid !== (i == 7 || i == 15)) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp %b", i, o_valid, (i == 7 || i == 15)); end
            if (i == 7 || i == 15) begin
                checks++;
                if (o_data !== 10'h100) begin errors++; $display("FAIL b2b_data[%0d] got %h exp 100", i, o_data); end
            end
        end
        step(1'b0, 12'h000, 1'b0, 1'b0);
        checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
    endtask

    task automatic test_gaps;
        int pulses;
        int accepted;
        pulses   = 0;
        accepted = 0;
        for (int i = 0; i < 40 && accepted < 8; i++) begin
            if ((i % 3) == 1 || (i % 5) == 4) begin
                step(1'b0, 12'h7FF, 1'b0, 1'b0);
            end else begin
                step(1'b1, 12'h080, 1'b0, 1'b0);
                accepted++;
            end
            if (o_valid === 1'b1) pulses++;
        end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid got %b exp 1", o_valid); end
        checks++; if (o_data !== 10'h100) begin errors++; $display("FAIL gaps_data got %h exp 100", o_data); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL gaps_pulses got %0d exp 1", pulses); end
        step(1'b0, 12'h000, 1'b0, 1'b0);
    endtask

    task automatic test_clear;
        for (int i = 0; i < 5; i++) step(1'b1, 12'h200, 1'b0, 1'b0);
        step(1'b1, 12'h200, 1'b1, 1'b0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got %b exp 0", o_valid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL clear_busy got %b exp 0", o_busy); end
        run_block(12'h080, 10'h100, 1'b0, "after_clear");
    endtask

    task automatic test_reset_mid;
        int pulses;
        pulses = 0;
        run_block(12'h200, 10'h1FF, 1'b1, "pre_reset");
        for (int i = 0; i < 4; i++) step(1'b1, 12'h200, 1'b0, 1'b0);
        step(1'b1, 12'h200, 1'b0, 1'b1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", o_valid); end
        checks++; if (o_data !== 10'h000) begin errors++; $display("FAIL rst_mid_data got %h exp 000", o_data); end
        checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL rst_mid_sat got %b exp 0", o_sat); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", o_busy); end
        for (int i = 0; i < 10; i++) begin
            step((i < 8), 12'h080, 1'b0, 1'b0);
            if (o_valid === 1'b1) begin
                pulses++;
                checks++;
                if (o_data !== 10'h100) begin errors++; $display("FAIL rst_mid_post_data got %h exp 100", o_data); end
            end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL rst_mid_pulses got %0d exp 1", pulses); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_back_to_back();
        test_gaps();
        test_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
